// File: rtl/piece_generator_pkg.sv
// piece_generator_pkg: game state codes, piece codes, board size, spawn FSM states, LFSR step and candidate helpers
package piece_generator_pkg;
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  typedef enum logic [2:0] {
    INITIAL        = 3'd0,
    GENERATE_PIECE = 3'd1,
    FALLING        = 3'd2,
    CLEAR_LINES    = 3'd3,
    GAME_OVER      = 3'd4
  } game_state_e;
  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_e;
  typedef enum logic [1:0] {IDLE, DRAW, CHECK, DONE} gen_state_e;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction
  function automatic logic [2:0] draw_candidate(input logic [15:0] l);
    return l[2:0] != 3'd7 ? l[2:0] : l[5:3] != 3'd7 ? l[5:3] : 3'd0;
  endfunction
endpackage

// File: rtl/piece_shape_rom.sv
// piece_shape_rom: combinational piece_type/rot/row/col -> cells (four 8-bit board indices, ascending, cell0 in [7:0]); rotation turns offsets clockwise in a 4x4 box
module piece_shape_rom
  import piece_generator_pkg::*;
(
  input  logic [2:0]  piece_type,
  input  logic [1:0]  rot,
  input  logic [4:0]  row,
  input  logic [3:0]  col,
  output logic [31:0] cells
);
  logic [15:0] offs;
  logic [1:0] rr [4];
  logic [1:0] cc [4];
  logic [7:0] c [4];
  logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3, d1, d2;
  always_comb begin
    case (piece_type)
      PIECE_O: offs = 16'h6521;
      PIECE_T: offs = 16'h5210;
      PIECE_S: offs = 16'h5421;
      PIECE_Z: offs = 16'h6510;
      PIECE_J: offs = 16'h6540;
      PIECE_L: offs = 16'h6542;
      default: offs = 16'h3210;
    endcase
  end
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rr[i] = offs[i*4+2 +: 2];
      cc[i] = offs[i*4 +: 2];
      for (int k = 0; k < 3; k++)
        if (2'(k) < rot) {rr[i], cc[i]} = {cc[i], 2'd3 - rr[i]};
      c[i] = (8'(row) + 8'(rr[i])) * 8'(BOARD_W) + 8'(col) + 8'(cc[i]);
    end
  end
  function automatic logic [15:0] cs(input logic [7:0] x, input logic [7:0] y);
    return x > y ? {y, x} : {x, y};
  endfunction
  assign {a0, a1} = cs(c[0], c[1]);
  assign {a2, a3} = cs(c[2], c[3]);
  assign {b0, b2} = cs(a0, a2);
  assign {b1, b3} = cs(a1, a3);
  assign {d1, d2} = cs(b1, b2);
  assign cells = {b3, d2, d1, b0};
endmodule

// File: rtl/piece_generator.sv
// piece_generator: spawn stage; on entry to GENERATE_PIECE draws a piece from the LFSR, places it at (0,SPAWN_COL), checks blocks_exist and pulses gen_done with game_next_state_gen FALLING/GAME_OVER; define PIECE_SEVEN_BAG_EN for 7-bag draws
module piece_generator
  import piece_generator_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SPAWN_COL = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 game_current_state,
  input  logic [BOARD_W*BOARD_H-1:0] blocks_exist,
  output logic [2:0]                 piece_type,
  output logic [1:0]                 piece_rot,
  output logic [4:0]                 piece_row,
  output logic [3:0]                 piece_col,
  output logic [31:0]                piece_cells,
  output logic [2:0]                 next_piece_type,
  output logic                       gen_done,
  output logic [2:0]                 game_next_state_gen
);
  gen_state_e st;
  logic [15:0] lfsr;
  logic armed, coll, gp, hit;
  logic [2:0] cand, pick;
  logic [31:0] spawn_cells;
  logic [255:0] board;
  assign gp = game_current_state == GENERATE_PIECE;
  assign cand = draw_candidate(lfsr);
  assign board = 256'(blocks_exist);
  assign hit = board[spawn_cells[7:0]] | board[spawn_cells[15:8]] | board[spawn_cells[23:16]] | board[spawn_cells[31:24]];
  piece_shape_rom u_rom (
    .piece_type(piece_type),
    .rot(2'd0),
    .row(5'd0),
    .col(4'(SPAWN_COL)),
    .cells(spawn_cells)
  );
`ifdef PIECE_SEVEN_BAG_EN
  logic [6:0] used, avail;
  logic [3:0] j;
  assign avail = &used ? 7'd0 : used;
  always_comb begin
    pick = cand;
    j = '0;
    for (int i = 6; i >= 0; i--) begin
      j = 4'(cand) + 4'(i);
      j = j > 4'd6 ? j - 4'd7 : j;
      if (!avail[j[2:0]]) pick = j[2:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) used <= '0;
    else if (st == DRAW && gp) used <= avail | (7'd1 << pick);
`else
  assign pick = cand;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED;
    else lfsr <= lfsr_next(lfsr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      armed <= 1'b1;
      coll <= 1'b0;
      piece_type <= '0;
      piece_rot <= '0;
      piece_row <= '0;
      piece_col <= 4'(SPAWN_COL);
      piece_cells <= '0;
      next_piece_type <= '0;
      gen_done <= 1'b0;
      game_next_state_gen <= INITIAL;
    end else begin
      gen_done <= 1'b0;
      armed <= !gp || (armed && st != IDLE);
      case (st)
        IDLE: st <= gp && armed ? DRAW : IDLE;
        DRAW: begin
          st <= gp ? CHECK : IDLE;
          if (gp) begin
            piece_type <= next_piece_type;
            next_piece_type <= pick;
          end
        end
        CHECK: begin
          st <= gp ? DONE : IDLE;
          if (gp) begin
            piece_cells <= spawn_cells;
            piece_row <= '0;
            piece_col <= 4'(SPAWN_COL);
            piece_rot <= '0;
            coll <= hit;
          end
        end
        DONE: begin
          gen_done <= 1'b1;
          game_next_state_gen <= coll ? GAME_OVER : FALLING;
          st <= IDLE;
        end
      endcase
    end
endmodule
